seq_alu: RTL

- Parametrised, registered successor of the single-cycle datapath ALU.
- Keeps the existing 4-bit ALUctl encoding for logic, add, subtract, set-less-than and NOR; each completes one cycle after acceptance.
- Adds an iterative signed multiplier and, optionally, an unsigned divider.
- Sits in the EX stage of the multi-cycle CPU; the control unit stalls on ready_o.

---
 rtl/seq_alu.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered EX-stage ALU with an iterative signed multiplier and an
// optional iterative unsigned divider.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, undefined codes) write their
// outputs at the accepting edge and keep ready_o high, so one result per
// cycle is possible. MUL (and DIVU when built) run one bit per cycle for WIDTH
// cycles with ready_o low, then write outputs and pulse done_o.
//
// Optional feature macro: SEQ_ALU_DIVU_EN
//   defined   : opcode 9 is an iterative unsigned divide (DIV state built)
//   undefined : opcode 9 behaves as an undefined single-cycle code
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   valid_i      operation request, accepted when ready_o is high
//   ready_o      block can accept a new operation (IDLE)
//   ctl_i        4-bit operation code
//   a_i, b_i     two's-complement operands
//   result_o     result / MUL low product / DIVU quotient
//   result_hi_o  MUL high product / DIVU remainder / else 0
//   zero_o       result_o == 0
//   overflow_o   ADD/SUB signed overflow, MUL not representable, DIVU by 0
//   done_o       one-cycle pulse: outputs just updated

module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             done_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;
`ifdef SEQ_ALU_DIVU_EN
    localparam logic [3:0] OP_DIVU = 4'd9;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef SEQ_ALU_DIVU_EN
        ,
        S_DIV  = 2'd2
`endif
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             last;
    logic             accept;

    // Iteration registers: MUL uses {hi,lo} as the shifting product with
    // the multiplier in lo; DIVU uses hi as partial remainder, lo as quotient.
    logic [WIDTH-1:0] opm;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;

    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    mul_prod;
    logic [PW-1:0]    mul_fin;
    logic [WIDTH:0]   mul_top;
    logic             mul_ovf;

`ifdef SEQ_ALU_DIVU_EN
    logic [WIDTH-1:0] dvd;
    logic             dz;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_dif;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
`endif

    logic             ready_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             ovf_q;
    logic             done_q;

    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;
    assign done_o      = done_q;

    assign accept = valid_i & ready_q;
    assign cnt_nx = cnt + CNT_W'(1);
    assign last   = (cnt_nx == CNT_W'(WIDTH));

    // Operand magnitudes; |most negative| fits in WIDTH unsigned bits.
    assign a_mag = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    assign b_mag = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && (ctl_i == OP_MUL)) begin
                    state_nx = S_MUL;
                end
`ifdef SEQ_ALU_DIVU_EN
                else if (accept && (ctl_i == OP_DIVU)) begin
                    state_nx = S_DIV;
                end
`endif
            end
            S_MUL: begin
                if (last) state_nx = S_IDLE;
            end
`ifdef SEQ_ALU_DIVU_EN
            S_DIV: begin
                if (last) state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Single-cycle result and overflow
    always_comb begin
        sum    = a_i + b_i;
        dif    = a_i - b_i;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ctl_i)
            OP_AND: sc_res = a_i & b_i;
            OP_OR:  sc_res = a_i | b_i;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_NOR: sc_res = ~(a_i | b_i);
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add step; sign applied to the full product at the last step
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opm} : '0);
        mul_prod = {mul_sum, lo[WIDTH-1:1]};
        mul_fin  = neg ? (~mul_prod + PW'(1)) : mul_prod;
        mul_top  = mul_fin[PW-1:WIDTH-1];
        mul_ovf  = ~((&mul_top) | ~(|mul_top));
    end

`ifdef SEQ_ALU_DIVU_EN
    // One restoring-division step
    always_comb begin
        rem_sh  = {hi, lo[WIDTH-1]};
        rem_dif = rem_sh - {1'b0, opm};
        q_bit   = ~rem_dif[WIDTH];
        rem_nx  = q_bit ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx  = {lo[WIDTH-2:0], q_bit};
    end
`endif

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            opm         <= '0;
            hi          <= '0;
            lo          <= '0;
            neg         <= 1'b0;
`ifdef SEQ_ALU_DIVU_EN
            dvd         <= '0;
            dz          <= 1'b0;
`endif
            ready_q     <= 1'b1;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            ready_q <= (state_nx == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (ctl_i == OP_MUL) begin
                            opm <= a_mag;
                            hi  <= '0;
                            lo  <= b_mag;
                            neg <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                        end
`ifdef SEQ_ALU_DIVU_EN
                        else if (ctl_i == OP_DIVU) begin
                            opm <= b_i;
                            hi  <= '0;
                            lo  <= a_i;
                            dvd <= a_i;
                            dz  <= (b_i == '0);
                        end
`endif
                        else begin
                            result_q    <= sc_res;
                            result_hi_q <= '0;
                            zero_q      <= (sc_res == '0);
                            ovf_q       <= sc_ovf;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    cnt      <= cnt_nx;
                    {hi, lo} <= mul_prod;
                    if (last) begin
                        result_q    <= mul_fin[WIDTH-1:0];
                        result_hi_q <= mul_fin[PW-1:WIDTH];
                        zero_q      <= (mul_fin[WIDTH-1:0] == '0);
                        ovf_q       <= mul_ovf;
                        done_q      <= 1'b1;
                    end
                end
`ifdef SEQ_ALU_DIVU_EN
                S_DIV: begin
                    cnt <= cnt_nx;
                    hi  <= rem_nx;
                    lo  <= quo_nx;
                    if (last) begin
                        // Divide by zero still iterates; result is forced here.
                        if (dz) begin
                            result_q    <= '1;
                            result_hi_q <= dvd;
                            zero_q      <= 1'b0;
                            ovf_q       <= 1'b1;
                        end else begin
                            result_q    <= quo_nx;
                            result_hi_q <= rem_nx;
                            zero_q      <= (quo_nx == '0);
                            ovf_q       <= 1'b0;
                        end
                        done_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
